// File: rtl/trace_sink_if.sv
// rtl/trace_sink_if.sv - output word stream interface between trace_sink and its consumer
interface trace_sink_if #(
    parameter int XLEN = 32
) ();
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_data_o;
    logic            out_last_o;
    logic            out_kind_o;

    modport master (
        output out_valid_o,
        output out_data_o,
        output out_last_o,
        output out_kind_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o,
        input  out_kind_o,
        output out_ready_i
    );
endinterface

// File: rtl/trace_sink.sv
// rtl/trace_sink.sv - commit trace FIFO and word serializer with optional memory dump (TRACE_MEMDUMP_EN)
module trace_sink #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [4:0]      reg_addr_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic            stall_i,
    trace_sink_if.master    out_if,
    output logic [15:0]     drop_cnt_o,
    input  logic            dump_start_i,
    input  logic [XLEN-1:0] dump_base_i,
    input  logic [7:0]      dump_len_i,
    output logic [XLEN-1:0] addr_o,
    input  logic [XLEN-1:0] data_i,
    output logic            dump_busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Record storage; pointers carry one extra bit so full and empty differ.
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [4:0]      rd_mem    [DEPTH];
    logic [XLEN-1:0] data_mem  [DEPTH];

    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count;
    logic [1:0]      widx_q, widx_d;
    logic [15:0]     drop_q, drop_d;
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   wr_idx;

    logic            capture;
    logic            push;
    logic            pop;
    logic            trace_allow;
    logic            trace_valid;
    logic            dump_emit;
    logic            dump_last;
    logic [XLEN-1:0] dump_word;

    assign count  = wr_ptr_q - rd_ptr_q;
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign wr_idx = wr_ptr_q[AW-1:0];

    assign capture     = !stall_i && (instr_i != '0);
    assign trace_valid = trace_allow && (count != '0);
    assign pop         = trace_valid && out_if.out_ready_i && (widx_q == 2'd3);
    // A full FIFO still accepts a record when its head record leaves this cycle.
    assign push        = capture && ((count < FULL_CNT) || pop);

`ifdef TRACE_MEMDUMP_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_READ,
        S_EMIT
    } dump_state_e;

    dump_state_e     state_q, state_d;
    logic [XLEN-1:0] base_q, base_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] ddata_q, ddata_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      idx_q, idx_d;

    // Trace words may only finish a record already under way while a dump waits.
    assign trace_allow = (state_q == S_IDLE) || ((state_q == S_WAIT) && (widx_q != 2'd0));
    assign dump_emit   = (state_q == S_EMIT);
    assign dump_last   = (idx_q == (len_q - 8'd1));
    assign dump_word   = ddata_q;
    assign addr_o      = addr_q;
    assign dump_busy_o = (state_q != S_IDLE);

    // Dump FSM next-state: latch request, wait for record boundary, then address/read/emit per word.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        ddata_d = ddata_q;
        len_d   = len_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (dump_start_i && (dump_len_i != 8'd0)) begin
                    state_d = S_WAIT;
                    base_d  = dump_base_i;
                    len_d   = dump_len_i;
                    idx_d   = 8'd0;
                end
            end
            S_WAIT: begin
                if (widx_q == 2'd0) begin
                    state_d = S_ADDR;
                    addr_d  = base_q;
                end
            end
            S_ADDR: begin
                state_d = S_READ;
            end
            S_READ: begin
                state_d = S_EMIT;
                ddata_d = data_i;
            end
            S_EMIT: begin
                if (out_if.out_ready_i) begin
                    if (dump_last) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ADDR;
                        idx_d   = idx_q + 8'd1;
                        addr_d  = addr_q + XLEN'(4);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Dump FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            ddata_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            ddata_q <= ddata_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end
`else
    logic unused_dump;

    assign unused_dump = ^{dump_start_i, dump_base_i, dump_len_i, data_i};
    assign trace_allow = 1'b1;
    assign dump_emit   = 1'b0;
    assign dump_last   = 1'b0;
    assign dump_word   = '0;
    assign addr_o      = '0;
    assign dump_busy_o = 1'b0;
`endif

    // Output mux: dump word when emitting a dump, else current word of the head record.
    always_comb begin
        out_if.out_valid_o = 1'b0;
        out_if.out_data_o  = '0;
        out_if.out_last_o  = 1'b0;
        out_if.out_kind_o  = 1'b0;
        if (dump_emit) begin
            out_if.out_valid_o = 1'b1;
            out_if.out_data_o  = dump_word;
            out_if.out_last_o  = dump_last;
            out_if.out_kind_o  = 1'b1;
        end else if (trace_valid) begin
            out_if.out_valid_o = 1'b1;
            out_if.out_last_o  = (widx_q == 2'd3);
            case (widx_q)
                2'd0:    out_if.out_data_o = pc_mem[rd_idx];
                2'd1:    out_if.out_data_o = instr_mem[rd_idx];
                2'd2:    out_if.out_data_o = {{(XLEN-5){1'b0}}, rd_mem[rd_idx]};
                default: out_if.out_data_o = data_mem[rd_idx];
            endcase
        end
    end

    // FIFO pointer, serializer index and drop counter next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        widx_d   = widx_q;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (trace_valid && out_if.out_ready_i) begin
            widx_d = widx_q + 2'd1;
        end
        if (capture && !push && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            widx_q   <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            widx_q   <= widx_d;
            drop_q   <= drop_d;
        end
    end

    // Record payload write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (rstn_i && push) begin
            pc_mem[wr_idx]    <= pc_i;
            instr_mem[wr_idx] <= instr_i;
            rd_mem[wr_idx]    <= reg_addr_i;
            data_mem[wr_idx]  <= reg_data_i;
        end
    end

    assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_trace_sink.sv
// tb/tb_trace_sink.sv - self-checking bench for trace_sink against a record/word queue model
module tb_trace_sink;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic [XLEN-1:0] pc, instr, rdata;
    logic [4:0]      rd;
    logic            stall;
    logic [15:0]     drop_cnt;
    logic            dump_start;
    logic [XLEN-1:0] dump_base;
    logic [7:0]      dump_len;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] mem_data;
    logic            dump_busy;

    trace_sink_if #(.XLEN(XLEN)) out_if ();

    trace_sink #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .pc_i         (pc),
        .instr_i      (instr),
        .reg_addr_i   (rd),
        .reg_data_i   (rdata),
        .stall_i      (stall),
        .out_if       (out_if),
        .drop_cnt_o   (drop_cnt),
        .dump_start_i (dump_start),
        .dump_base_i  (dump_base),
        .dump_len_i   (dump_len),
        .addr_o       (addr),
        .data_i       (mem_data),
        .dump_busy_o  (dump_busy)
    );

    always #5 clk = ~clk;

    // Memory model for the dump port.
    assign mem_data = addr ^ 32'h0000_00A5;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    int          mrec = 0;
    int          mdrop = 0;
    int          words_seen = 0;
    int          n_captured = 0;
    logic        prev_stalled = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        instr = '0;
        stall = 1'b0;
        pc    = '0;
        rd    = '0;
        rdata = '0;
    endtask

    task automatic rand_commit();
        pc    = $urandom & 32'hFFFF_FFFC;
        instr = $urandom | 32'h1;
        rd    = 5'($urandom);
        rdata = $urandom;
        stall = 1'b0;
    endtask

    // One clock: check outputs at negedge against the model, update the model, step the edge.
    task automatic cyc();
        logic hs;
        logic hs_last;
        @(negedge clk);
        chk("valid_vs_model", {31'b0, out_if.out_valid_o}, {31'b0, exp_q.size() != 0});
        if (prev_stalled) begin
            chk("hold_data", out_if.out_data_o, prev_data);
            chk("hold_last", {31'b0, out_if.out_last_o}, {31'b0, prev_last});
        end
        hs      = out_if.out_valid_o && out_if.out_ready_i;
        hs_last = 1'b0;
        if (hs && exp_q.size() != 0) begin
            chk("word_data", out_if.out_data_o, exp_q[0]);
            chk("word_last", {31'b0, out_if.out_last_o}, {31'b0, exp_last_q[0]});
            chk("word_kind", {31'b0, out_if.out_kind_o}, 32'd0);
            hs_last = exp_last_q[0];
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
            words_seen++;
            if (hs_last) mrec--;
        end
        prev_stalled = out_if.out_valid_o && !out_if.out_ready_i;
        prev_data    = out_if.out_data_o;
        prev_last    = out_if.out_last_o;
        if (!rstn) begin
            exp_q.delete();
            exp_last_q.delete();
            mrec         = 0;
            mdrop        = 0;
            prev_stalled = 1'b0;
        end else if (!stall && instr != '0) begin
            if (mrec < DEPTH) begin
                exp_q.push_back(pc);
                exp_q.push_back(instr);
                exp_q.push_back({27'b0, rd});
                exp_q.push_back(rdata);
                exp_last_q.push_back(1'b0);
                exp_last_q.push_back(1'b0);
                exp_last_q.push_back(1'b0);
                exp_last_q.push_back(1'b1);
                mrec++;
                n_captured++;
            end else if (mdrop < 65535) begin
                mdrop++;
            end
        end
        @(posedge clk);
        #1;
        chk("drop_cnt", {16'b0, drop_cnt}, mdrop);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, out_if.out_valid_o}, 32'd0);
        chk({tag, "_data"}, out_if.out_data_o, 32'd0);
        chk({tag, "_last"}, {31'b0, out_if.out_last_o}, 32'd0);
        chk({tag, "_kind"}, {31'b0, out_if.out_kind_o}, 32'd0);
        chk({tag, "_drop"}, {16'b0, drop_cnt}, 32'd0);
        chk({tag, "_addr"}, addr, 32'd0);
        chk({tag, "_busy"}, {31'b0, dump_busy}, 32'd0);
    endtask

`ifdef TRACE_MEMDUMP_EN
    // Run one dump and check every word against base+4*i and the memory model.
    task automatic dump_run(input logic [31:0] base, input logic [7:0] len);
        int          i;
        logic [31:0] a;
        dump_start = 1'b1;
        dump_base  = base;
        dump_len   = len;
        @(posedge clk);
        #1;
        dump_start = 1'b0;
        i = 0;
        for (int c = 0; c < 200 && i < int'(len); c++) begin
            @(negedge clk);
            if (out_if.out_valid_o && out_if.out_ready_i) begin
                a = base + 32'(4 * i);
                chk("dump_addr", addr, a);
                chk("dump_data", out_if.out_data_o, a ^ 32'h0000_00A5);
                chk("dump_kind", {31'b0, out_if.out_kind_o}, 32'd1);
                chk("dump_last", {31'b0, out_if.out_last_o}, {31'b0, i == int'(len) - 1});
                chk("dump_busy", {31'b0, dump_busy}, 32'd1);
                i++;
            end
            @(posedge clk);
            #1;
            dump_start = (c == 1);
            dump_len   = len + 8'd2;
            out_if.out_ready_i = ($urandom_range(0, 3) != 0);
        end
        dump_start = 1'b0;
        out_if.out_ready_i = 1'b1;
        chk("dump_word_count", i, {24'b0, len});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("dump_quiet_valid", {31'b0, out_if.out_valid_o}, 32'd0);
            chk("dump_done_busy", {31'b0, dump_busy}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        int w0;
        rstn       = 1'b0;
        dump_start = 1'b0;
        dump_base  = '0;
        dump_len   = '0;
        out_if.out_ready_i = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) cyc();
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Single known record on a free-running consumer.
        pc    = 32'h80;
        instr = 32'h0050_0093;
        rd    = 5'd1;
        rdata = 32'd5;
        stall = 1'b0;
        w0 = words_seen;
        cyc();
        idle_inputs();
        for (int k = 0; k < 6; k++) cyc();
        chk("single_record_words", words_seen - w0, 32'd4);

        // Stalled or null commits must not capture or count as drops.
        for (int k = 0; k < 6; k++) begin
            rand_commit();
            if (k % 2 == 0) stall = 1'b1;
            else            instr = '0;
            cyc();
        end
        idle_inputs();
        cyc();
        cyc();
        chk("no_capture_drop", {16'b0, drop_cnt}, 32'd0);

        // Overflow: ten commits into a blocked 8-record FIFO.
        out_if.out_ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rand_commit();
            cyc();
        end
        idle_inputs();
        cyc();
        chk("overflow_drop", {16'b0, drop_cnt}, 32'd2);
        out_if.out_ready_i = 1'b1;
        w0 = words_seen;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) cyc();
        cyc();
        chk("overflow_words", words_seen - w0, 32'd32);

        // Random backpressure and commit traffic over at least 100 captured records.
        w0 = n_captured;
        for (int k = 0; k < 5000 && (n_captured - w0) < 100; k++) begin
            if ($urandom_range(0, 1) != 0) rand_commit();
            else                           idle_inputs();
            if ($urandom_range(0, 7) == 0) stall = 1'b1;
            out_if.out_ready_i = ($urandom_range(0, 2) != 0);
            cyc();
        end
        chk("random_records_captured", {31'b0, (n_captured - w0) >= 100}, 32'd1);
        idle_inputs();
        out_if.out_ready_i = 1'b1;
        for (int k = 0; k < 600 && exp_q.size() != 0; k++) cyc();
        chk("random_drained", exp_q.size(), 32'd0);

        // Reset while word2 of a record is presented.
        rand_commit();
        cyc();
        idle_inputs();
        for (int k = 0; k < 20 && exp_q.size() > 2; k++) cyc();
        chk("reset_mid_pending", exp_q.size(), 32'd2);
        rstn = 1'b0;
        cyc();
        check_reset_outputs("midreset");
        rstn = 1'b1;
        cyc();
        rand_commit();
        w0 = words_seen;
        cyc();
        idle_inputs();
        for (int k = 0; k < 6; k++) cyc();
        chk("post_reset_words", words_seen - w0, 32'd4);

`ifdef TRACE_MEMDUMP_EN
        dump_run(32'h0000_0100, 8'd3);
        dump_run(32'hFFFF_FFF8, 8'd4);
        dump_run($urandom & 32'hFFFF_FFFC, 8'($urandom_range(1, 9)));
`else
        dump_start = 1'b1;
        dump_base  = 32'h0000_0100;
        dump_len   = 8'd3;
        cyc();
        dump_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("nodump_addr", addr, 32'd0);
            chk("nodump_busy", {31'b0, dump_busy}, 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
